// File: rtl/sap_core.sv
// sap_core: parametrised accumulator CPU with handshaked memory and UART-send ports.
//
// One posedge control FSM (FETCH / EXEC / TXWAIT / HALT) runs a 4-bit-opcode ISA.
// Operands are the low DATA_WIDTH-4 bits of the instruction word.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   mem_addr     memory address (combinational from state, PC and IR)
//   mem_req      memory access requested this cycle
//   mem_we       write qualifier, only meaningful with mem_req
//   mem_wdata    write data (accumulator)
//   mem_rdata    read data, valid when mem_ready
//   mem_ready    access completes in a cycle where mem_req && mem_ready
//   out_data     LED register
//   out_strobe   one-cycle pulse while out_data shows a freshly written value
//   tx_data      byte to send (accumulator)
//   tx_valid     send request, held until tx_ready
//   tx_ready     UART accepts when tx_valid && tx_ready
//   halted       core stopped
//   illegal      core stopped on an undefined opcode
//
// DATA_WIDTH must be at least 6 and OUT_WIDTH must not exceed DATA_WIDTH.
module sap_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-5:0] mem_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_strobe,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  halted,
  output logic                  illegal
);

  localparam int unsigned ADDR_WIDTH = DATA_WIDTH - 4;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpLda  = 4'd1;
  localparam logic [3:0] OpAdd  = 4'd2;
  localparam logic [3:0] OpSub  = 4'd3;
  localparam logic [3:0] OpSta  = 4'd4;
  localparam logic [3:0] OpOut  = 4'd5;
  localparam logic [3:0] OpJmp  = 4'd6;
  localparam logic [3:0] OpLdi  = 4'd7;
  localparam logic [3:0] OpJc   = 4'd8;
  localparam logic [3:0] OpSnda = 4'd9;
  localparam logic [3:0] OpJz   = 4'd10;
  localparam logic [3:0] OpHlt  = 4'd15;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StTxWait,
    StHalt
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0]   ir_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic                    c_q;
  logic                    z_q;
  logic [OUT_WIDTH-1:0]    out_data_q;
  logic                    out_strobe_q;
  logic                    illegal_q;

  logic [3:0]              opcode;
  logic [ADDR_WIDTH-1:0]   operand;
  logic [DATA_WIDTH:0]     add_res;
  logic [DATA_WIDTH:0]     sub_res;
  logic                    req_raw;
  logic                    we_raw;

  assign opcode  = ir_q[DATA_WIDTH-1 -: 4];
  assign operand = ir_q[ADDR_WIDTH-1:0];

  // Carry out of the subtract is the inverted borrow: C=1 means A >= rdata.
  assign add_res = {1'b0, a_q} + {1'b0, mem_rdata};
  assign sub_res = {1'b0, a_q} + {1'b0, ~mem_rdata} + (DATA_WIDTH + 1)'(1);

  // Memory request decode, purely from state and PC/IR so it is stable across waits.
  always_comb begin
    req_raw  = 1'b0;
    we_raw   = 1'b0;
    mem_addr = pc_q;
    unique case (state_q)
      StFetch: begin
        req_raw = 1'b1;
      end
      StExec: begin
        case (opcode)
          OpLda, OpAdd, OpSub: begin
            req_raw  = 1'b1;
            mem_addr = operand;
          end
          OpSta: begin
            req_raw  = 1'b1;
            we_raw   = 1'b1;
            mem_addr = operand;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Gating with rst_n drops requests the moment reset asserts, even though the
  // reset state is FETCH.
  assign mem_req    = req_raw & rst_n;
  assign mem_we     = we_raw & rst_n;
  assign mem_wdata  = a_q;
  assign tx_data    = a_q;
  assign tx_valid   = (state_q == StTxWait);
  assign halted     = (state_q == StHalt);
  assign illegal    = illegal_q;
  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= '0;
      ir_q         <= '0;
      a_q          <= '0;
      c_q          <= 1'b0;
      z_q          <= 1'b0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      out_strobe_q <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + ADDR_WIDTH'(1);
            state_q <= StExec;
          end
        end
        StExec: begin
          state_q <= StFetch;
          case (opcode)
            OpNop: ;
            OpLda: begin
              if (mem_ready) begin
                a_q <= mem_rdata;
                z_q <= (mem_rdata == '0);
              end else begin
                state_q <= StExec;
              end
            end
            OpAdd: begin
              if (mem_ready) begin
                {c_q, a_q} <= add_res;
                z_q        <= (add_res[DATA_WIDTH-1:0] == '0);
              end else begin
                state_q <= StExec;
              end
            end
            OpSub: begin
              if (mem_ready) begin
                {c_q, a_q} <= sub_res;
                z_q        <= (sub_res[DATA_WIDTH-1:0] == '0);
              end else begin
                state_q <= StExec;
              end
            end
            OpSta: begin
              if (!mem_ready) begin
                state_q <= StExec;
              end
            end
            OpOut: begin
              out_data_q   <= a_q[OUT_WIDTH-1:0];
              out_strobe_q <= 1'b1;
            end
            OpJmp: begin
              pc_q <= operand;
            end
            OpLdi: begin
              a_q <= {4'b0000, operand};
              z_q <= (operand == '0);
            end
            OpJc: begin
              if (c_q) begin
                pc_q <= operand;
              end
            end
            OpSnda: begin
              state_q <= StTxWait;
            end
            OpJz: begin
              if (z_q) begin
                pc_q <= operand;
              end
            end
            OpHlt: begin
              state_q <= StHalt;
            end
            default: begin
              state_q   <= StHalt;
              illegal_q <= 1'b1;
            end
          endcase
        end
        StTxWait: begin
          if (tx_ready) begin
            state_q <= StFetch;
          end
        end
        StHalt: ;
        default: state_q <= StHalt;
      endcase
    end
  end

endmodule
